// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared definitions for the register bank:
//   - DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default parameter values
//   - clr_state_e                             : clear sequencer states
// -----------------------------------------------------------------------------
package register_bank_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage : register_bank_pkg

// File: rtl/register_bank_clr_fsm.sv
// -----------------------------------------------------------------------------
// register_bank_clr_fsm
// Clear sequencer for register_bank. When a clear is requested in IDLE it
// walks clr_ptr from 0 to DEPTH-1, one entry per cycle, then returns to IDLE.
// The pointer is only meaningful while clr_we is high.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   clr_req  in   request to start a clear sweep (ignored while sweeping)
//   idle     out  FSM is in IDLE (writes may be accepted)
//   clr_we   out  zero mem[clr_ptr] on this clock edge
//   clr_ptr  out  entry being cleared this cycle
//   busy     out  registered, high for the whole sweep
//   clr_done out  registered one-cycle pulse after the last entry is cleared
// -----------------------------------------------------------------------------
module register_bank_clr_fsm
  import register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  idle,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_ptr,
  output logic                  busy,
  output logic                  clr_done
);

  // Last entry of the array: DEPTH-1 is all ones at ADDR_WIDTH bits.
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = '1;

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic                  busy_q;
  logic                  clr_done_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values that existed before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          // Pointer wraps back to 0 after the last entry.
          clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
          if (clr_ptr_q == LAST_PTR) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle     = (state_q == IDLE);
  assign clr_we   = (state_q == CLEAR);
  assign clr_ptr  = clr_ptr_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule : register_bank_clr_fsm

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// 2**ADDR_WIDTH x DATA_WIDTH register file with one write port, two
// independent combinational read ports and a sequenced clear-all sweep.
// Optional address-0 hardwired zero (ZERO_REG=1).
//
// Build option: define REGISTER_BANK_BYPASS_EN to forward w_data to a read
// port in the same cycle when that port addresses the location being written.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears all entries)
//   wr_en    in   write request
//   w_addr   in   write address
//   w_data   in   write data
//   r_addr   in   read port 1 address
//   r2_addr  in   read port 2 address
//   r_data   out  read port 1 data (combinational)
//   r2_data  out  read port 2 data (combinational)
//   clr_req  in   single-cycle request to clear all entries
//   busy     out  high while a clear sweep runs
//   wr_ack   out  registered pulse the cycle after an accepted write
//   clr_done out  registered pulse the cycle after the sweep completes
// -----------------------------------------------------------------------------
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] r2_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  wr_ack,
  output logic                  clr_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  idle;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_ptr;

  register_bank_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .idle     (idle),
    .clr_we   (clr_we),
    .clr_ptr  (clr_ptr),
    .busy     (busy),
    .clr_done (clr_done)
  );

  // ---------------------------------------------------------------------------
  // Write qualification: a clear request in the same cycle wins over a write,
  // and writes are ignored entirely during a sweep.
  // ---------------------------------------------------------------------------
  logic wr_ok;
  logic wr_zero_hit;
  logic wr_accept;

  assign wr_ok       = wr_en && idle && !clr_req;
  assign wr_zero_hit = (ZERO_REG != 0) && (w_addr == '0);
  assign wr_accept   = wr_ok && !wr_zero_hit;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_ack_q;
  logic                  wr_ack_d;

  // NOTE: every always_comb output gets a full default first (here the
  // current contents), so no path leaves a signal unassigned and no latch
  // is inferred.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_ptr] = '0;
    end else if (wr_accept) begin
      mem_d[w_addr] = w_data;
    end
  end

  assign wr_ack_d = wr_accept;

  // NOTE: the array is reset like any other register because reset must
  // leave every entry reading 0; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ack_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;

  // ---------------------------------------------------------------------------
  // Read ports. A hardwired-zero hit takes precedence over bypass so that
  // address 0 never echoes write data when ZERO_REG is set.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_data = mem_q[r_addr];
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_ok && (r_addr == w_addr)) begin
      r_data = w_data;
    end
`endif
    if ((ZERO_REG != 0) && (r_addr == '0)) begin
      r_data = '0;
    end
  end

  always_comb begin
    r2_data = mem_q[r2_addr];
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_ok && (r2_addr == w_addr)) begin
      r2_data = w_data;
    end
`endif
    if ((ZERO_REG != 0) && (r2_addr == '0)) begin
      r2_data = '0;
    end
  end

endmodule : register_bank

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each register and of every data port.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 0, SHALL hardwire address 0 when set to 1: reads return 0 and writes are ignored.
REQ-004 The block has one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_en  input  1  write request for the current cycle.
REQ-008 w_addr  input  ADDR_WIDTH  write address.
REQ-009 w_data  input  DATA_WIDTH  write data.
REQ-010 r_addr  input  ADDR_WIDTH  read port 1 address.
REQ-011 r2_addr  input  ADDR_WIDTH  read port 2 address.
REQ-012 r_data  output  DATA_WIDTH  read port 1 data.
REQ-013 r2_data  output  DATA_WIDTH  read port 2 data.
REQ-014 clr_req  input  1  single-cycle request to clear all registers.
REQ-015 busy  output  1  high while a clear sweep is in progress.
REQ-016 wr_ack  output  1  registered pulse, high for one cycle after each accepted write.
REQ-017 clr_done  output  1  registered pulse, high for one cycle when the sweep completes.

Function
REQ-018 Both read ports SHALL be combinational and independent; r_data = mem[r_addr] and r2_data = mem[r2_addr] in the same cycle.
REQ-019 In IDLE, wr_en=1 with clr_req=0 SHALL write w_data to mem[w_addr] on the rising edge; wr_ack SHALL be 1 in the following cycle.
REQ-020 The FSM SHALL have two states: IDLE and CLEAR.
REQ-021 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with clr_ptr=0; busy SHALL go to 1 in the next cycle.
REQ-022 In CLEAR, each cycle SHALL write 0 to mem[clr_ptr] and increment clr_ptr; the sweep SHALL take exactly DEPTH cycles.
REQ-023 When clr_ptr=DEPTH-1 is written, the FSM SHALL return to IDLE, busy SHALL drop and clr_done SHALL pulse in the next cycle.
REQ-024 clr_req in the same cycle as wr_en in IDLE SHALL take priority: the write is dropped and wr_ack stays 0.
REQ-025 In CLEAR, wr_en SHALL be ignored (no write, wr_ack=0) and clr_req SHALL be ignored (the sweep is not restarted).
REQ-026 During CLEAR, reads SHALL return the current array contents: 0 for entries already swept, old values for the rest.
REQ-027 With ZERO_REG=1, reads of address 0 SHALL return 0 and a write to address 0 SHALL produce no wr_ack.
REQ-028 clr_ptr SHALL be ADDR_WIDTH bits wide and SHALL wrap naturally; it SHALL not be used outside CLEAR.

Reset
REQ-029 When rst_n=0, all registers SHALL be set to 0 immediately, independent of clk.
REQ-030 Reset SHALL force the FSM to IDLE and set busy=0, wr_ack=0, clr_done=0 and clr_ptr=0.
REQ-031 A reset during CLEAR SHALL abort the sweep, and clr_done SHALL not pulse.

Configuration
REQ-032 Macro REGISTER_BANK_BYPASS_EN, when defined, SHALL enable write-through bypass on both read ports.
REQ-033 With bypass, when wr_en=1, the state is IDLE, clr_req=0 and the read address equals w_addr (not a hardwired zero), that port SHALL output w_data in the same cycle.
REQ-034 Without REGISTER_BANK_BYPASS_EN, read ports SHALL return the stored value; new data SHALL be visible the cycle after the write.

Structure
REQ-035 Package register_bank_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-036 The clear sequencer (FSM, clr_ptr, busy, clr_done) SHALL be the sub-module register_bank_clr_fsm; the storage array and read logic remain in register_bank.

Verification
REQ-037 Write 8'h45 to addr 0, then read on both ports with r_addr=0 and r2_addr=0 -> both ports return 8'h45; wr_ack pulses once.
REQ-038 Write to addr 7 with r_addr=7 in the same cycle -> r_data=new value that cycle with bypass, old value that cycle and new the next without bypass.
REQ-039 Fill all 8 entries with nonzero data, pulse clr_req -> busy high for 8 cycles, entries zeroed in order 0..7, clr_done pulses once.
REQ-040 Assert wr_en and clr_req together, then wr_en during busy -> no writes, wr_ack stays 0; after the sweep all entries read 0.
REQ-041 Pull rst_n low mid-sweep -> all entries read 0 immediately, busy=0, no clr_done pulse.
REQ-042 With ZERO_REG=1, write 8'hFF to addr 0 -> r_data=0 and no wr_ack pulse.
